// File: rtl/pe_operand_sequencer_if.sv
// Operand-pair stream into the PE operand sequencer (valid/ready with last marker).
interface pe_operand_sequencer_if #(
  parameter int unsigned WIDTH_DATA = 16
);
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [WIDTH_DATA-1:0] s_a_i;
  logic [WIDTH_DATA-1:0] s_b_i;
  logic                  s_last_i;

  modport master (output s_valid_i, s_a_i, s_b_i, s_last_i, input s_ready_o);
  modport slave  (input s_valid_i, s_a_i, s_b_i, s_last_i, output s_ready_o);
endinterface

// File: rtl/pe_operand_sequencer.sv
// PE operand sequencer: feeds operand pairs to a process element, frames dot
// products with pe_format_en_o and reports each completed result RES_LAT
// cycles after the format cycle that closes it.
// Optional feature: define PE_SEQ_AUTOFLUSH_EN to build the idle-gap timer
// that flushes a closed dot product after FLUSH_GAP idle cycles.
module pe_operand_sequencer #(
  parameter int unsigned WIDTH_DATA = 16,
  parameter int unsigned LEN_MAX    = 256,
  parameter int unsigned RES_LAT    = 4,
  parameter int unsigned FLUSH_GAP  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  pe_operand_sequencer_if.slave          op,
  input  logic                           flush_i,
  output logic [WIDTH_DATA-1:0]          pe_a_o,
  output logic [WIDTH_DATA-1:0]          pe_b_o,
  output logic                           pe_format_en_o,
  output logic                           res_valid_o,
  output logic [$clog2(LEN_MAX+1)-1:0]   res_len_o,
  output logic                           err_o
);

  localparam int unsigned LW = $clog2(LEN_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_FLUSH, FLUSH} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   cnt, cnt_nx, cnt_inc;
  logic            xfer, first, over, last_eff, close, gap_hit;
  logic            close_q;
  logic [LW-1:0]   close_len_q;
  logic            dl_vld [RES_LAT];
  logic [LW-1:0]   dl_len [RES_LAT];

`ifdef PE_SEQ_AUTOFLUSH_EN
  localparam int unsigned GW = $clog2(FLUSH_GAP + 1);
  logic [GW-1:0] gap;

  // Idle-cycle counter while a closed dot product waits to be drained
  always_ff @(posedge clk) begin
    if (!rst_n)                            gap <= '0;
    else if (state != WAIT_FLUSH || xfer)  gap <= '0;
    else                                   gap <= gap + GW'(1);
  end

  assign gap_hit = (gap == GW'(FLUSH_GAP - 1));
`else
  assign gap_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state, pair counting and dot-product framing
  always_comb begin
    state_nx = state;
    xfer     = op.s_valid_i && op.s_ready_o;
    first    = xfer && (state != ACCUM);
    cnt_inc  = first ? LW'(1) : cnt + LW'(1);
    over     = xfer && !op.s_last_i && (cnt_inc == LW'(LEN_MAX));
    last_eff = op.s_last_i || (cnt_inc == LW'(LEN_MAX));
    cnt_nx   = xfer ? cnt_inc : cnt;
    unique case (state)
      IDLE: begin
        if (xfer) state_nx = last_eff ? WAIT_FLUSH : ACCUM;
      end
      ACCUM: begin
        if (xfer)         state_nx = last_eff ? WAIT_FLUSH : ACCUM;
        else if (flush_i) state_nx = FLUSH;
      end
      WAIT_FLUSH: begin
        if (xfer)                    state_nx = last_eff ? WAIT_FLUSH : ACCUM;
        else if (flush_i || gap_hit) state_nx = FLUSH;
      end
      default: state_nx = IDLE;
    endcase
    // A format cycle closes a previous dot product unless it opens the first after IDLE
    close = (xfer && state == WAIT_FLUSH) || (state_nx == FLUSH);
  end

  // Registered PE drive, handshake, error flag and close marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      op.s_ready_o   <= 1'b0;
      pe_a_o         <= '0;
      pe_b_o         <= '0;
      pe_format_en_o <= 1'b0;
      err_o          <= 1'b0;
      close_q        <= 1'b0;
      close_len_q    <= '0;
    end else begin
      cnt            <= cnt_nx;
      op.s_ready_o   <= (state_nx != FLUSH);
      pe_a_o         <= xfer ? op.s_a_i : '0;
      pe_b_o         <= xfer ? op.s_b_i : '0;
      pe_format_en_o <= first || (state_nx == FLUSH);
      err_o          <= err_o || over;
      close_q        <= close;
      close_len_q    <= close ? cnt : '0;
    end
  end

  // Result delay line aligning the close marker with the PE result latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RES_LAT); i++) begin
        dl_vld[i] <= 1'b0;
        dl_len[i] <= '0;
      end
    end else begin
      dl_vld[0] <= close_q;
      dl_len[0] <= close_len_q;
      for (int i = 1; i < int'(RES_LAT); i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_len[i] <= dl_len[i-1];
      end
    end
  end

  assign res_valid_o = dl_vld[RES_LAT-1];
  assign res_len_o   = dl_len[RES_LAT-1];

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Scoreboard bench for pe_operand_sequencer: directed dot products on a
// default-parameter instance (index 0) and a LEN_MAX=4 instance (index 1).
`timescale 1ns/1ps
module tb_pe_operand_sequencer;

  typedef struct {int cyc; logic [15:0] a; logic [15:0] b; logic fmt;} pe_exp_t;
  typedef struct {int cyc; int len;} res_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        vld [2];
  logic        lst [2];
  logic        fl  [2];
  logic [15:0] av  [2];
  logic [15:0] bv  [2];

  pe_exp_t  pq0[$], pq1[$];
  res_exp_t rq0[$], rq1[$];

  logic [15:0] a_pa, a_pb, b_pa, b_pb;
  logic        a_fmt, a_rv, a_err, b_fmt, b_rv, b_err;
  logic [8:0]  a_rl;
  logic [2:0]  b_rl;

  pe_operand_sequencer_if #(.WIDTH_DATA(16)) opa ();
  pe_operand_sequencer_if #(.WIDTH_DATA(16)) opb ();

  assign opa.s_valid_i = vld[0];
  assign opa.s_last_i  = lst[0];
  assign opa.s_a_i     = av[0];
  assign opa.s_b_i     = bv[0];
  assign opb.s_valid_i = vld[1];
  assign opb.s_last_i  = lst[1];
  assign opb.s_a_i     = av[1];
  assign opb.s_b_i     = bv[1];

  pe_operand_sequencer #(.WIDTH_DATA(16), .LEN_MAX(256), .RES_LAT(4), .FLUSH_GAP(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(opa), .flush_i(fl[0]),
    .pe_a_o(a_pa), .pe_b_o(a_pb), .pe_format_en_o(a_fmt),
    .res_valid_o(a_rv), .res_len_o(a_rl), .err_o(a_err));

  pe_operand_sequencer #(.WIDTH_DATA(16), .LEN_MAX(4), .RES_LAT(4), .FLUSH_GAP(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .op(opb), .flush_i(fl[1]),
    .pe_a_o(b_pa), .pe_b_o(b_pb), .pe_format_en_o(b_fmt),
    .res_valid_o(b_rv), .res_len_o(b_rl), .err_o(b_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? opa.s_ready_o : opb.s_ready_o;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one pair; expect it on the PE one cycle later, optionally a result closing the previous one
  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b,
                      input logic last, input logic fmt, input logic flsh, input int rlen);
    int n = 0;
    while (!rdy(d)) begin
      tick(1);
      n++;
      if (n > 20) begin
        checks++; errors++;
        $display("FAIL ready_timeout dut%0d: s_ready_o stayed 0, required 1", d);
        return;
      end
    end
    vld[d] = 1'b1; av[d] = a; bv[d] = b; lst[d] = last; fl[d] = flsh;
    tick(1);
    vld[d] = 1'b0; av[d] = '0; bv[d] = '0; lst[d] = 1'b0; fl[d] = 1'b0;
    if (d == 0) begin
      pq0.push_back('{cyc, a, b, fmt});
      if (rlen > 0) rq0.push_back('{cyc + 4, rlen});
    end else begin
      pq1.push_back('{cyc, a, b, fmt});
      if (rlen > 0) rq1.push_back('{cyc + 4, rlen});
    end
  endtask

  // Pulse flush_i; if a FLUSH is expected it shows as a zero-operand format cycle
  task automatic do_flush(input int d, input logic exp, input int rlen);
    fl[d] = 1'b1;
    tick(1);
    fl[d] = 1'b0;
    if (exp) begin
      if (d == 0) begin
        pq0.push_back('{cyc, 16'd0, 16'd0, 1'b1});
        if (rlen > 0) rq0.push_back('{cyc + 4, rlen});
      end else begin
        pq1.push_back('{cyc, 16'd0, 16'd0, 1'b1});
        if (rlen > 0) rq1.push_back('{cyc + 4, rlen});
      end
    end
  endtask

  task automatic mon_pe(input int d, input logic fmt, input logic [15:0] pa, input logic [15:0] pb);
    pe_exp_t e;
    if (!(fmt || pa != 0 || pb != 0)) return;
    checks++;
    if ((d == 0 && pq0.size() == 0) || (d == 1 && pq1.size() == 0)) begin
      errors++;
      $display("FAIL pe%0d_unexpected: cyc=%0d fmt=%0b a=%0d b=%0d, required no PE activity", d, cyc, fmt, pa, pb);
      return;
    end
    if (d == 0) e = pq0.pop_front(); else e = pq1.pop_front();
    if (e.cyc != cyc || e.a != pa || e.b != pb || e.fmt != fmt) begin
      errors++;
      $display("FAIL pe%0d_out: got cyc=%0d fmt=%0b a=%0d b=%0d, required cyc=%0d fmt=%0b a=%0d b=%0d",
               d, cyc, fmt, pa, pb, e.cyc, e.fmt, e.a, e.b);
    end
  endtask

  task automatic mon_res(input int d, input logic rv, input int rl);
    res_exp_t e;
    if (!rv) return;
    checks++;
    if ((d == 0 && rq0.size() == 0) || (d == 1 && rq1.size() == 0)) begin
      errors++;
      $display("FAIL res%0d_unexpected: cyc=%0d len=%0d, required no res_valid_o", d, cyc, rl);
      return;
    end
    if (d == 0) e = rq0.pop_front(); else e = rq1.pop_front();
    if (e.cyc != cyc || e.len != rl) begin
      errors++;
      $display("FAIL res%0d_out: got cyc=%0d len=%0d, required cyc=%0d len=%0d", d, cyc, rl, e.cyc, e.len);
    end
  endtask

  // Monitor: compare every PE/result presentation against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      mon_pe(0, a_fmt, a_pa, a_pb);
      mon_pe(1, b_fmt, b_pa, b_pb);
      mon_res(0, a_rv, int'(a_rl));
      mon_res(1, b_rv, int'(b_rl));
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; fl[i] = 1'b0; av[i] = '0; bv[i] = '0;
    end
    rst_n = 1'b0;
    tick(3);
    chk("reset_pe_a", int'(a_pa), 0);
    chk("reset_pe_b", int'(a_pb), 0);
    chk("reset_fmt", int'(a_fmt), 0);
    chk("reset_res_valid", int'(a_rv), 0);
    chk("reset_res_len", int'(a_rl), 0);
    chk("reset_err", int'(a_err), 0);
    chk("reset_ready", int'(opa.s_ready_o), 0);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_reset", int'(opa.s_ready_o), 1);

    // Three-pair dot product, then no traffic
    send(0, 16'd1, 16'd2, 1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd3, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    send(0, 16'd5, 16'd6, 1'b1, 1'b0, 1'b0, 0);
`ifdef PE_SEQ_AUTOFLUSH_EN
    pq0.push_back('{cyc + 8, 16'd0, 16'd0, 1'b1});
    rq0.push_back('{cyc + 12, 3});
    tick(16);
`else
    tick(100);
    do_flush(0, 1'b1, 3);
    tick(8);
`endif

    // Back-to-back dot products of 2 and 5 pairs
    send(0, 16'd7,  16'd8,  1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd9,  16'd10, 1'b1, 1'b0, 1'b0, 0);
    send(0, 16'd11, 16'd12, 1'b0, 1'b1, 1'b0, 2);
    send(0, 16'd13, 16'd14, 1'b0, 1'b0, 1'b0, 0);
    send(0, 16'd15, 16'd16, 1'b0, 1'b0, 1'b0, 0);
    send(0, 16'd17, 16'd18, 1'b0, 1'b0, 1'b0, 0);
    send(0, 16'd19, 16'd20, 1'b1, 1'b0, 1'b0, 0);
    do_flush(0, 1'b1, 5);
    tick(8);

    // flush_i coinciding with an accepted pair in ACCUM is ignored
    send(0, 16'd21, 16'd22, 1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd23, 16'd24, 1'b0, 1'b0, 1'b1, 0);
    chk("ready_after_flush_collision", int'(opa.s_ready_o), 1);
    send(0, 16'd25, 16'd26, 1'b1, 1'b0, 1'b0, 0);
    do_flush(0, 1'b1, 3);
    tick(6);

    // flush_i in IDLE is ignored
    do_flush(0, 1'b0, 0);
    tick(6);
    chk("ready_idle_flush", int'(opa.s_ready_o), 1);

    // flush_i closes a dot product still open in ACCUM
    send(0, 16'd31, 16'd32, 1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd33, 16'd34, 1'b0, 1'b0, 1'b0, 0);
    do_flush(0, 1'b1, 2);
    tick(8);

`ifdef PE_SEQ_AUTOFLUSH_EN
    // Transfer in the gap-expiry cycle wins over the automatic flush
    send(0, 16'd51, 16'd52, 1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd53, 16'd54, 1'b1, 1'b0, 1'b0, 0);
    tick(7);
    send(0, 16'd55, 16'd56, 1'b0, 1'b1, 1'b0, 2);
    send(0, 16'd57, 16'd58, 1'b1, 1'b0, 1'b0, 0);
    do_flush(0, 1'b1, 2);
    tick(8);
`endif

    // Reset two cycles after a FLUSH drops the pending result
    send(0, 16'd41, 16'd42, 1'b0, 1'b1, 1'b0, 0);
    send(0, 16'd43, 16'd44, 1'b1, 1'b0, 1'b0, 0);
    do_flush(0, 1'b1, 0);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("rst_mid_pe_a", int'(a_pa), 0);
    chk("rst_mid_fmt", int'(a_fmt), 0);
    chk("rst_mid_res_valid", int'(a_rv), 0);
    chk("rst_mid_res_len", int'(a_rl), 0);
    chk("rst_mid_ready", int'(opa.s_ready_o), 0);
    tick(10);

    // LEN_MAX=4 instance: six pairs without last
    send(1, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 0);
    send(1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0, 0);
    send(1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0, 0);
    chk("err_before_overlength", int'(b_err), 0);
    send(1, 16'd4, 16'd4, 1'b0, 1'b0, 1'b0, 0);
    chk("err_on_pair4", int'(b_err), 1);
    send(1, 16'd5, 16'd5, 1'b0, 1'b1, 1'b0, 4);
    send(1, 16'd6, 16'd6, 1'b0, 1'b0, 1'b0, 0);
    do_flush(1, 1'b1, 2);
    tick(8);
    chk("err_sticky", int'(b_err), 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("err_cleared_by_reset", int'(b_err), 0);

    // Drain the scoreboard with a bounded wait
    n = 0;
    while ((pq0.size() + pq1.size() + rq0.size() + rq1.size()) != 0 && n < 50) begin
      tick(1);
      n++;
    end
    chk("pending_pe0", pq0.size(), 0);
    chk("pending_pe1", pq1.size(), 0);
    chk("pending_res0", rq0.size(), 0);
    chk("pending_res1", rq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
